fetch_unit: RTL

//  Program-counter register and instruction-fetch sequencer for the MIPS core.
//  - Issues word fetches to instruction memory over a req/ack handshake.
//  - Presents each fetched instruction and its PC+4 to the decode stage over a valid/ready handshake.
//  - Consumes the 32-bit sign-extended branch offset from sign_extender to compute branch targets.
//  - Computes jump targets from the 26-bit J-type index.

---
 rtl/fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction fetch sequencer (optional exception redirect: FETCH_EXC_EN)
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        id_ready,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_offset,
    input  logic        jump,
`ifdef FETCH_EXC_EN
    input  logic        exc_req,
`endif
    input  logic [25:0] jump_target
);

`ifdef FETCH_EXC_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_VALID  = 2'd2,
        S_SQUASH = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } state_t;
`endif

    state_t      state;
    state_t      state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] instr_n;
    logic [31:0] pc_plus4_n;
    logic        instr_valid_n;

    logic        accept;
    logic [31:0] seq_pc;
    logic [31:0] branch_pc;
    logic [31:0] jump_pc;

`ifdef FETCH_EXC_EN
    // Address of the fetch that was in flight when an exception hit; the
    // memory still has to see it completed before the new stream starts.
    logic [31:0] squash_addr;
    logic [31:0] squash_addr_n;
`else
    logic        unused_exc_vector;
    assign unused_exc_vector = ^EXC_VECTOR;
`endif

    // Offset is a word count; its top two bits fall off the <<2 and do not matter.
    logic        unused_offset_msbs;
    assign unused_offset_msbs = ^branch_offset[31:30];

    // Candidate next-PC values, all modulo 2^32.
    always_comb begin
        accept    = instr_valid & id_ready & ~stall;
        seq_pc    = pc + 32'd4;
        branch_pc = pc_plus4 + {branch_offset[29:0], 2'b00};
        jump_pc   = {pc_plus4[31:28], jump_target, 2'b00};
    end

    // Next-state and output decode for the fetch sequencer.
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_n       = instr;
        pc_plus4_n    = pc_plus4;
        instr_valid_n = instr_valid;
        imem_req      = 1'b0;
        imem_addr     = pc;
`ifdef FETCH_EXC_EN
        squash_addr_n = squash_addr;
`endif
        case (state)
            S_IDLE: begin
                state_n = S_REQ;
`ifdef FETCH_EXC_EN
                if (exc_req) begin
                    pc_n          = EXC_VECTOR;
                    instr_valid_n = 1'b0;
                end
`endif
            end

            S_REQ: begin
                imem_req = 1'b1;
`ifdef FETCH_EXC_EN
                if (exc_req) begin
                    // Request cannot be withdrawn: either it completes now and
                    // its data is dropped, or it is drained in SQUASH.
                    pc_n = EXC_VECTOR;
                    if (imem_ack) begin
                        state_n = S_REQ;
                    end else begin
                        squash_addr_n = pc;
                        state_n       = S_SQUASH;
                    end
                end else
`endif
                if (imem_ack) begin
                    instr_n       = imem_rdata;
                    pc_plus4_n    = seq_pc;
                    pc_n          = seq_pc;
                    instr_valid_n = 1'b1;
                    state_n       = S_VALID;
                end
            end

            S_VALID: begin
`ifdef FETCH_EXC_EN
                if (exc_req) begin
                    pc_n          = EXC_VECTOR;
                    instr_valid_n = 1'b0;
                    state_n       = S_REQ;
                end else
`endif
                if (accept) begin
                    // pc already holds pc_plus4 here; only redirects change it.
                    instr_valid_n = 1'b0;
                    state_n       = S_REQ;
                    if (jump) begin
                        pc_n = jump_pc;
                    end else if (branch_taken) begin
                        pc_n = branch_pc;
                    end
                end
            end

`ifdef FETCH_EXC_EN
            S_SQUASH: begin
                imem_req  = 1'b1;
                imem_addr = squash_addr;
                if (imem_ack) begin
                    state_n = S_REQ;
                end
            end
`endif

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset takes effect immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= {RESET_PC[31:2], 2'b00};
            instr       <= 32'h0;
            pc_plus4    <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr       <= instr_n;
            pc_plus4    <= pc_plus4_n;
            instr_valid <= instr_valid_n;
        end
    end

`ifdef FETCH_EXC_EN
    // Address of the request being drained after an exception.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_addr <= 32'h0;
        end else begin
            squash_addr <= squash_addr_n;
        end
    end
`endif

endmodule
